wb_ctrl_regs: RTL and testbench

WB_CTRL_REGS -- requirements
Module: wb_ctrl_regs

---
 rtl/wb_ctrl_regs.sv | 173 +++++++++++++++++
 tb/tb_wb_ctrl_regs.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_ctrl_regs.sv
// wb_ctrl_regs: Wishbone classic control/status register block
// with IRQ pending/enable and a sequenced core reset.
module wb_ctrl_regs #(
  parameter int          NREGS     = 4,
  parameter logic [31:0] ADDR_BASE = 32'h3000_0000,
  parameter int          WAIT      = 0,
  parameter int          RST_HOLD  = 16,
  parameter int          IRQ_W     = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wbs_cyc_i,
  input  logic             wbs_stb_i,
  input  logic             wbs_we_i,
  input  logic [3:0]       wbs_sel_i,
  input  logic [31:0]      wbs_adr_i,
  input  logic [31:0]      wbs_dat_i,
  output logic             wbs_ack_o,
  output logic [31:0]      wbs_dat_o,
  input  logic [31:0]      status_i,
  input  logic [IRQ_W-1:0] irq_src_i,
  output logic [31:0]      ctrl_o,
  output logic             core_rst_n_o,
  output logic [IRQ_W-1:0] irq_o
);

  localparam int NS = (NREGS > 4) ? NREGS - 4 : 1;

  typedef enum logic [1:0] {
    S_HOLD,
    S_COUNT,
    S_RUN
  } seq_e;

  logic             sel_w;
  logic [3:0]       off_w;
  logic             unused_adr;
  logic             wr_w;
  logic [1:0]       wcnt_q, wcnt_d;
  logic             ack_q, ack_d;
  logic [31:0]      dat_q, rdata;
  logic [31:0]      ctrl_q, ctrl_d;
  logic [IRQ_W-1:0] pend_q, pend_d;
  logic [IRQ_W-1:0] en_q, en_d;
  logic [IRQ_W-1:0] prev_q, clr_w;
  logic [31:0]      scr_q [NS];
  seq_e             seq_q;
  logic [7:0]       cnt_q;
  logic             core_rst_q;

  function automatic logic [31:0] merge(
    input logic [31:0] o,
    input logic [31:0] n,
    input logic [3:0]  s
  );
    logic [31:0] r;
    for (int b = 0; b < 4; b++)
      r[8*b +: 8] = s[b] ? n[8*b +: 8] : o[8*b +: 8];
    return r;
  endfunction

  assign sel_w = wbs_cyc_i & wbs_stb_i &
                 (wbs_adr_i[31:6] == ADDR_BASE[31:6]);
  assign off_w = wbs_adr_i[5:2];
  assign unused_adr = ^wbs_adr_i[1:0];

  // The cycle after an ack never counts toward a new access.
  always_comb begin
    wcnt_d = '0;
    ack_d  = 1'b0;
    if (sel_w && !ack_q) begin
      if (wcnt_q == 2'(WAIT)) ack_d = 1'b1;
      else wcnt_d = wcnt_q + 2'd1;
    end
  end

  assign wr_w = ack_d & wbs_we_i;

  always_comb begin
    ctrl_d = ctrl_q;
    en_d   = en_q;
    clr_w  = '0;
    if (wr_w && off_w == 4'd0)
      ctrl_d = merge(ctrl_q, wbs_dat_i, wbs_sel_i);
    if (wr_w && off_w == 4'd3 && wbs_sel_i[0])
      en_d = wbs_dat_i[IRQ_W-1:0];
    if (wr_w && off_w == 4'd2 && wbs_sel_i[0])
      clr_w = wbs_dat_i[IRQ_W-1:0];
    pend_d = (pend_q & ~clr_w) | (irq_src_i & ~prev_q);
  end

  always_comb begin
    rdata = '0;
    case (off_w)
      4'd0:    rdata = ctrl_q;
      4'd1:    rdata = status_i;
      4'd2:    rdata = 32'(pend_q);
      4'd3:    rdata = 32'(en_q);
      default: begin
        for (int i = 0; i < NS; i++)
          if (off_w == 4'(i + 4) && (i + 4) < NREGS)
            rdata = scr_q[i];
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt_q <= '0;
      ack_q  <= 1'b0;
      dat_q  <= '0;
      ctrl_q <= '0;
      en_q   <= '0;
      pend_q <= '0;
      prev_q <= '0;
    end else begin
      wcnt_q <= wcnt_d;
      ack_q  <= ack_d;
      dat_q  <= ack_d ? rdata : '0;
      ctrl_q <= ctrl_d;
      en_q   <= en_d;
      pend_q <= pend_d;
      prev_q <= irq_src_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NS; i++) scr_q[i] <= '0;
    end else begin
      for (int i = 0; i < NS; i++)
        if (wr_w && off_w == 4'(i + 4) && (i + 4) < NREGS)
          scr_q[i] <= merge(scr_q[i], wbs_dat_i, wbs_sel_i);
    end
  end

  // Clearing CTRL[0] always wins and drops the core back into reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seq_q      <= S_HOLD;
      cnt_q      <= '0;
      core_rst_q <= 1'b0;
    end else if (!ctrl_q[0]) begin
      seq_q      <= S_HOLD;
      cnt_q      <= '0;
      core_rst_q <= 1'b0;
    end else begin
      case (seq_q)
        S_HOLD: begin
          seq_q <= S_COUNT;
          cnt_q <= '0;
        end
        S_COUNT: begin
          if (cnt_q == 8'(RST_HOLD - 1)) begin
            seq_q      <= S_RUN;
            core_rst_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        S_RUN:   core_rst_q <= 1'b1;
        default: seq_q <= S_HOLD;
      endcase
    end
  end

  assign wbs_ack_o    = ack_q;
  assign wbs_dat_o    = dat_q;
  assign ctrl_o       = ctrl_q;
  assign core_rst_n_o = core_rst_q;
  assign irq_o        = pend_q & en_q;

endmodule

// File: tb/tb_wb_ctrl_regs.sv
// tb_wb_ctrl_regs: directed vectors with a scoreboard queue
// popped by an ack monitor.
module tb_wb_ctrl_regs;

  localparam int          NREGS = 8;
  localparam int          WAIT  = 2;
  localparam int          RSTH  = 16;
  localparam int          IRQ_W = 3;
  localparam logic [31:0] B     = 32'h3000_0000;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             cyc, stb, we;
  logic [3:0]       sel;
  logic [31:0]      adr, dat;
  logic             ack;
  logic [31:0]      rdat;
  logic [31:0]      status;
  logic [IRQ_W-1:0] irq_src;
  logic [31:0]      ctrl;
  logic             core_rst_n;
  logic [IRQ_W-1:0] irq;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          chk;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t q[$];

  bit seen_rise = 1'b0;

  always #5 clk = ~clk;

  wb_ctrl_regs #(
    .NREGS    (NREGS),
    .ADDR_BASE(B),
    .WAIT     (WAIT),
    .RST_HOLD (RSTH),
    .IRQ_W    (IRQ_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wbs_cyc_i   (cyc),
    .wbs_stb_i   (stb),
    .wbs_we_i    (we),
    .wbs_sel_i   (sel),
    .wbs_adr_i   (adr),
    .wbs_dat_i   (dat),
    .wbs_ack_o   (ack),
    .wbs_dat_o   (rdat),
    .status_i    (status),
    .irq_src_i   (irq_src),
    .ctrl_o      (ctrl),
    .core_rst_n_o(core_rst_n),
    .irq_o       (irq)
  );

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (ack === 1'b1) begin
      if (q.size() == 0) begin
        chk("unexpected_ack", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (e.chk) chk(e.name, rdat, e.exp);
      end
    end
  end

  always @(posedge core_rst_n) seen_rise = 1'b1;

  task automatic wb(input string nm, input bit w,
                    input logic [31:0] a, input logic [31:0] d,
                    input logic [3:0] s, input logic [31:0] exp,
                    input bit exp_ack, input bit hold);
    int n;
    bit got;
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = w;
    adr = a; dat = d; sel = s;
    if (exp_ack) q.push_back('{!w, exp, nm});
    n = 0;
    got = 1'b0;
    while (!got && n < 8) begin
      @(posedge clk); #1;
      n++;
      got = ack;
    end
    if (exp_ack) chk({nm, "_lat"}, 32'(n), 32'(WAIT + 1));
    else chk({nm, "_noack"}, 32'(got), 32'd0);
    if (hold && got) begin
      @(posedge clk); #1;
      chk({nm, "_hold"}, 32'(ack), 32'd0);
    end
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic rise_after(input string nm, input int exp);
    int n;
    n = 0;
    while (!core_rst_n && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk(nm, 32'(n), 32'(exp));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    bit acc;
    rst_n = 1'b0;
    cyc = 0; stb = 0; we = 0; sel = 0; adr = 0; dat = 0;
    status = 32'hCAFE_F00D;
    irq_src = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_dat", rdat, 32'd0);
    chk("rst_ctrl", ctrl, 32'd0);
    chk("rst_core", 32'(core_rst_n), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    @(negedge clk) rst_n = 1'b1;

    wb("scr_wr", 1, B + 32'h10, 32'h1234_5678, 4'b0101, 0, 1, 0);
    wb("scr_rd", 0, B + 32'h10, 0, 4'hF, 32'h0034_0078, 1, 0);
    wb("scr_rd_lo", 0, B + 32'h13, 0, 4'hF, 32'h0034_0078, 1, 0);
    wb("scr5_rd", 0, B + 32'h14, 0, 4'hF, 32'h0, 1, 0);

    wb("stat_rd", 0, B + 32'h4, 0, 4'hF, 32'hCAFE_F00D, 1, 1);
    wb("stat_wr", 1, B + 32'h4, 32'hFFFF_FFFF, 4'hF, 0, 1, 0);
    status = 32'h0BAD_BEEF;
    wb("stat_rd2", 0, B + 32'h4, 0, 4'hF, 32'h0BAD_BEEF, 1, 0);

    wb("oor_wr", 1, B + 32'h3C, 32'hFFFF_FFFF, 4'hF, 0, 1, 0);
    wb("oor_rd", 0, B + 32'h3C, 0, 4'hF, 32'h0, 1, 0);
    wb("miss_rd", 0, B + 32'h40, 0, 4'hF, 0, 0, 0);
    wb("miss_wr", 1, B + 32'h50, 32'hFFFF_FFFF, 4'hF, 0, 0, 0);
    wb("scr_keep", 0, B + 32'h10, 0, 4'hF, 32'h0034_0078, 1, 0);
    wb("ctrl_keep", 0, B, 0, 4'hF, 32'h0, 1, 0);

    @(negedge clk);
    cyc = 1; stb = 1; we = 1;
    adr = B + 32'h14; dat = 32'hDEAD_BEEF; sel = 4'hF;
    acc = 1'b0;
    repeat (WAIT) begin
      @(posedge clk); #1;
      acc |= ack;
    end
    @(negedge clk) stb = 1'b0;
    @(posedge clk); #1;
    acc |= ack;
    chk("abort_noack", 32'(acc), 32'd0);
    @(negedge clk) cyc = 1'b0; we = 1'b0;
    wb("abort_rd", 0, B + 32'h14, 0, 4'hF, 32'h0, 1, 0);

    wb("en_wr", 1, B + 32'hC, 32'hFFFF_FFFF, 4'hF, 0, 1, 0);
    wb("en_rd", 0, B + 32'hC, 0, 4'hF, 32'h7, 1, 0);
    wb("en_wr5", 1, B + 32'hC, 32'h5, 4'b0001, 0, 1, 0);
    wb("en_rd5", 0, B + 32'hC, 0, 4'hF, 32'h5, 1, 0);
    @(negedge clk) irq_src = 3'b111;
    @(negedge clk) irq_src = 3'b000;
    @(negedge clk);
    chk("irq_o_pend", 32'(irq), 32'h5);
    wb("pend_rd", 0, B + 32'h8, 0, 4'hF, 32'h7, 1, 0);
    fork
      wb("w1c_race", 1, B + 32'h8, 32'h1, 4'b0001, 0, 1, 0);
      begin
        @(negedge clk);
        repeat (WAIT) @(posedge clk);
        #2 irq_src = 3'b001;
      end
    join
    wb("pend_race", 0, B + 32'h8, 0, 4'hF, 32'h7, 1, 0);
    chk("irq_o_race", 32'(irq), 32'h5);
    @(negedge clk) irq_src = 3'b000;
    wb("w1c_nosel", 1, B + 32'h8, 32'h7, 4'b1110, 0, 1, 0);
    wb("pend_nosel", 0, B + 32'h8, 0, 4'hF, 32'h7, 1, 0);
    wb("w1c_all", 1, B + 32'h8, 32'h7, 4'b0001, 0, 1, 0);
    wb("pend_clr", 0, B + 32'h8, 0, 4'hF, 32'h0, 1, 0);
    chk("irq_o_clr", 32'(irq), 32'h0);

    chk("core_pre", 32'(core_rst_n), 32'd0);
    wb("ctrl_on", 1, B, 32'h1, 4'hF, 0, 1, 0);
    chk("ctrl_o_on", ctrl, 32'h1);
    rise_after("core_rise", RSTH + 1);
    wb("ctrl_off", 1, B, 32'h0, 4'hF, 0, 1, 0);
    @(posedge clk); #1;
    chk("core_fall", 32'(core_rst_n), 32'd0);
    seen_rise = 1'b0;
    wb("ctrl_on2", 1, B, 32'h1, 4'hF, 0, 1, 0);
    repeat (5) @(posedge clk);
    wb("ctrl_off2", 1, B, 32'h0, 4'hF, 0, 1, 0);
    repeat (RSTH + 4) @(posedge clk);
    #1;
    chk("core_stay_low", 32'(seen_rise), 32'd0);
    wb("ctrl_on3", 1, B, 32'h1, 4'hF, 0, 1, 0);
    rise_after("core_restart", RSTH + 1);

    wb("ctrl_full", 1, B, 32'hAABB_CCDD, 4'hF, 0, 1, 0);
    chk("ctrl_o_full", ctrl, 32'hAABB_CCDD);
    wb("ctrl_b3", 1, B, 32'h1100_0000, 4'b1000, 0, 1, 0);
    chk("ctrl_o_b3", ctrl, 32'h11BB_CCDD);
    wb("ctrl_rd", 0, B, 0, 4'hF, 32'h11BB_CCDD, 1, 0);

    @(negedge clk) irq_src = 3'b101;
    @(negedge clk) irq_src = 3'b000;
    repeat (RSTH + 4) @(posedge clk);
    #1;
    chk("pre_rst_core", 32'(core_rst_n), 32'd1);
    chk("pre_rst_irq", 32'(irq), 32'h5);

    @(negedge clk);
    cyc = 1; stb = 1; we = 0;
    adr = B + 32'h10; sel = 4'hF;
    @(posedge clk); #1;
    rst_n = 1'b0;
    acc = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      acc |= ack;
    end
    chk("mid_rst_noack", 32'(acc), 32'd0);
    chk("mid_rst_dat", rdat, 32'd0);
    chk("mid_rst_ctrl", ctrl, 32'd0);
    chk("mid_rst_core", 32'(core_rst_n), 32'd0);
    chk("mid_rst_irq", 32'(irq), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    q.push_back('{1'b1, 32'h0, "post_rst_rd"});
    n = 0;
    acc = 1'b0;
    while (!acc && n < 8) begin
      @(posedge clk); #1;
      n++;
      acc = ack;
    end
    chk("post_rst_lat", 32'(n), 32'(WAIT + 1));
    @(negedge clk);
    cyc = 0; stb = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("sb_empty", 32'(q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
